fs_port_arbiter: RTL

//   Sequences and shares the filesystem block between two swap clients (e.g. fetch, data) and one syscall client.
//   The filesystem has no ready handshake, so this block drives its strobes for a fixed window and waits a fixed latency.
//   It then captures the result and returns it to the granted client with a one-cycle done pulse.

---
 rtl/fs_port_arbiter_if.sv | 35 +++
 rtl/fs_port_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fs_port_arbiter_if.sv
// Signal bundle between the CPU-side clients, the filesystem block and fs_port_arbiter.
// master = arbiter view, slave = client/filesystem view.
interface fs_port_arbiter_if;
  logic [1:0]  swReq;
  logic [1:0]  swMeta;
  logic [63:0] swAddr;
  logic [1:0]  swWr;
  logic [63:0] swData;
  logic [1:0]  swDone;
  logic [31:0] swQ;
  logic        scReq;
  logic [7:0]  scId;
  logic        scDone;
  logic [31:0] scQ;
  logic        swapMeta;
  logic [31:0] swapAddress;
  logic        swapRden;
  logic        swapWren;
  logic [31:0] swapData;
  logic [31:0] swapQ;
  logic [7:0]  syscallId;
  logic [31:0] dataOut;

  modport master (
    input  swReq, swMeta, swAddr, swWr, swData, scReq, scId, swapQ, dataOut,
    output swDone, swQ, scDone, scQ, swapMeta, swapAddress, swapRden, swapWren, swapData,
           syscallId
  );

  modport slave (
    output swReq, swMeta, swAddr, swWr, swData, scReq, scId, swapQ, dataOut,
    input  swDone, swQ, scDone, scQ, swapMeta, swapAddress, swapRden, swapWren, swapData,
           syscallId
  );
endinterface

// File: rtl/fs_port_arbiter.sv
// Time-slices the handshake-less filesystem between two swap clients and one syscall client.
// Define FS_ARB_FAIR_EN for 3-way round-robin (sc -> sw0 -> sw1) instead of syscall priority.
module fs_port_arbiter #(
  parameter int unsigned STROBE_CYCLES   = 2,
  parameter int unsigned SWAP_LATENCY    = 8,
  parameter int unsigned SYSCALL_LATENCY = 64,
  parameter int unsigned CNT_W           = 8
) (
  input logic               CLOCK_50,
  input logic               reset,
  fs_port_arbiter_if.master bus
);
  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
  typedef enum logic [1:0] {GntSc, GntSw0, GntSw1} gnt_e;

  state_e           state_q, state_d;
  gnt_e             gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat_q, lat_d;
  logic             wr_q, wr_d, meta_q, meta_d;
  logic [31:0]      addr_q, addr_d, data_q, data_d;
  logic [31:0]      swq_q, swq_d, scq_q, scq_d;
  logic [7:0]       id_q, id_d;

  logic req_any;
  gnt_e req_sel;
  logic sw_idx;

`ifdef FS_ARB_FAIR_EN
  // ptr_q: 0 = sc, 1 = sw0, 2 = sw1; first requester at or after ptr_q wins
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] req_vec;
  logic [1:0] cand;

  always_comb begin
    req_vec = {bus.swReq, bus.scReq};
    req_any = 1'b0;
    req_sel = GntSc;
    cand    = 2'd0;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = 2'((3'(ptr_q) + 3'(k)) % 3'd3);
      if (!req_any && req_vec[cand]) begin
        req_any = 1'b1;
        req_sel = gnt_e'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StDone) begin
      unique case (gnt_q)
        GntSc:   ptr_d = 2'd1;
        GntSw0:  ptr_d = 2'd2;
        default: ptr_d = 2'd0;
      endcase
    end
  end
`else
  // ptr_q names the swap client that wins a tie
  logic ptr_q, ptr_d;

  always_comb begin
    req_any = bus.scReq | (|bus.swReq);
    if (bus.scReq)              req_sel = GntSc;
    else if (bus.swReq[ptr_q])  req_sel = ptr_q ? GntSw1 : GntSw0;
    else                        req_sel = ptr_q ? GntSw0 : GntSw1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StDone) begin
      if (gnt_q == GntSw0)      ptr_d = 1'b1;
      else if (gnt_q == GntSw1) ptr_d = 1'b0;
    end
  end
`endif

  assign sw_idx = (req_sel == GntSw1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    wr_d    = wr_q;
    meta_d  = meta_q;
    addr_d  = addr_q;
    data_d  = data_q;
    id_d    = id_q;
    swq_d   = swq_q;
    scq_d   = scq_q;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          state_d = StIssue;
          gnt_d   = req_sel;
          cnt_d   = CNT_W'(1);
          if (req_sel == GntSc) begin
            id_d  = bus.scId;
            lat_d = CNT_W'(SYSCALL_LATENCY);
          end else begin
            meta_d = bus.swMeta[sw_idx];
            wr_d   = bus.swWr[sw_idx];
            addr_d = sw_idx ? bus.swAddr[63:32] : bus.swAddr[31:0];
            data_d = sw_idx ? bus.swData[63:32] : bus.swData[31:0];
            lat_d  = CNT_W'(SWAP_LATENCY);
          end
        end
      end
      StIssue, StWait: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Latency check comes first so STROBE_CYCLES == latency still completes
        if (cnt_q == lat_q) begin
          state_d = StDone;
          if (gnt_q == GntSc) scq_d = bus.dataOut;
          else if (!wr_q)     swq_d = bus.swapQ;
        end else if (state_q == StIssue && cnt_q == CNT_W'(STROBE_CYCLES)) begin
          state_d = StWait;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= GntSc;
      cnt_q   <= '0;
      lat_q   <= '0;
      wr_q    <= 1'b0;
      meta_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      id_q    <= '0;
      swq_q   <= '0;
      scq_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      wr_q    <= wr_d;
      meta_q  <= meta_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      id_q    <= id_d;
      swq_q   <= swq_d;
      scq_q   <= scq_d;
      ptr_q   <= ptr_d;
    end
  end

  // Outputs decode from state so an asynchronous reset clears them in the same cycle
  logic active, sw_gnt;
  assign active = (state_q == StIssue) || (state_q == StWait);
  assign sw_gnt = (gnt_q != GntSc);

  assign bus.swapMeta    = active && sw_gnt && meta_q;
  assign bus.swapAddress = (active && sw_gnt) ? addr_q : 32'd0;
  assign bus.swapData    = (active && sw_gnt) ? data_q : 32'd0;
  assign bus.swapRden    = (state_q == StIssue) && sw_gnt && !wr_q;
  assign bus.swapWren    = (state_q == StIssue) && sw_gnt && wr_q;
  assign bus.syscallId   = (active && !sw_gnt) ? id_q : 8'd0;
  assign bus.swDone      = (state_q == StDone && sw_gnt) ?
                           ((gnt_q == GntSw1) ? 2'b10 : 2'b01) : 2'b00;
  assign bus.scDone      = (state_q == StDone) && !sw_gnt;
  assign bus.swQ         = swq_q;
  assign bus.scQ         = scq_q;
endmodule
